// File: rtl/key_sw_debouncer_pkg.sv
// Shared register selects and default debounce depth for the KEY/SW debouncer.
package key_sw_pkg;

    typedef enum logic [1:0] {
        RDSEL_KEY     = 2'd0,
        RDSEL_SW      = 2'd1,
        RDSEL_EVENTS  = 2'd2,
        RDSEL_IRQMASK = 2'd3
    } reg_sel_e;

    localparam int DEBOUNCE_CYCLES_DEF = 250000;

endpackage

// File: rtl/key_sw_debouncer_if.sv
// Select/data read port and write strobe between the UI controller and the debouncer.
interface key_sw_debouncer_if #(
    parameter int DBITS = 32
);
    logic [1:0]       rdSel;
    logic [DBITS-1:0] rdData;
    logic             wrtEn;
    logic [1:0]       wrtSel;
    logic [DBITS-1:0] wrtData;

    modport master (output rdSel, wrtEn, wrtSel, wrtData, input rdData);
    modport slave  (input rdSel, wrtEn, wrtSel, wrtData, output rdData);
endinterface

// File: rtl/key_sw_debouncer_debounce_cell.sv
// One input bit: 2-flop synchronizer followed by a stability counter guarding the stable value q.
module debounce_cell #(
    parameter int   DEBOUNCE_CYCLES = 250000,
    parameter logic RST_VAL         = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic q
);
    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          q_q, q_d;
    logic [CW-1:0] c_q, c_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        q_d     = q_q;
        c_d     = c_q;
        // Any sample matching q restarts the count, so only unbroken runs are accepted.
        if (sync2_q == q_q) begin
            c_d = '0;
        end else if (c_q == LAST) begin
            q_d = sync2_q;
            c_d = '0;
        end else begin
            c_d = c_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
            q_q     <= RST_VAL;
            c_q     <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            q_q     <= q_d;
            c_q     <= c_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/key_sw_debouncer.sv
// KEY/SW input conditioner with sticky W1C key-press events.
// Define KEY_DEBOUNCER_IRQ_EN to add the irqMask register and the irq output.
module key_sw_debouncer
    import key_sw_pkg::*;
#(
    parameter int DBITS           = 32,
    parameter int NKEYS           = 4,
    parameter int NSW             = 10,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NKEYS-1:0] keyRaw,
    input  logic [NSW-1:0]   swRaw,
    output logic [NKEYS-1:0] keyState,
    output logic [NSW-1:0]   swState,
    output logic [NKEYS-1:0] keyPress,
    key_sw_debouncer_if.slave bus
`ifdef KEY_DEBOUNCER_IRQ_EN
    ,
    output logic             irq
`endif
);
    localparam int NBITS = NKEYS + NSW;

    logic [NBITS-1:0] raw_all;
    logic [NBITS-1:0] q_all;

    assign raw_all = {swRaw, keyRaw};

    // Keys idle high on the board, so their cells reset to the released level.
    for (genvar i = 0; i < NBITS; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RST_VAL         (logic'(i < NKEYS))
        ) u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (raw_all[i]),
            .q       (q_all[i])
        );
    end

    assign keyState = ~q_all[NKEYS-1:0];
    assign swState  = q_all[NKEYS +: NSW];

    logic [NKEYS-1:0] key_prev_q, key_prev_d;
    logic [NKEYS-1:0] keyPress_q, keyPress_d;
    logic [NKEYS-1:0] events_q, events_d;
    logic [NKEYS-1:0] clr;
    logic [NKEYS-1:0] mask;

    always_comb begin
        clr = '0;
        if (bus.wrtEn && bus.wrtSel == RDSEL_EVENTS)
            clr = bus.wrtData[NKEYS-1:0];
        key_prev_d = keyState;
        keyPress_d = keyState & ~key_prev_q;
        // Set after clear so a press landing on a W1C write is never lost.
        events_d   = (events_q & ~clr) | keyPress_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_prev_q <= '0;
            keyPress_q <= '0;
            events_q   <= '0;
        end else begin
            key_prev_q <= key_prev_d;
            keyPress_q <= keyPress_d;
            events_q   <= events_d;
        end
    end

    assign keyPress = keyPress_q;

`ifdef KEY_DEBOUNCER_IRQ_EN
    logic [NKEYS-1:0] irqMask_q, irqMask_d;
    logic             irq_q, irq_d;

    always_comb begin
        irqMask_d = irqMask_q;
        if (bus.wrtEn && bus.wrtSel == RDSEL_IRQMASK)
            irqMask_d = bus.wrtData[NKEYS-1:0];
        irq_d = |(events_q & irqMask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqMask_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            irqMask_q <= irqMask_d;
            irq_q     <= irq_d;
        end
    end

    assign mask = irqMask_q;
    assign irq  = irq_q;
`else
    assign mask = '0;
`endif

    always_comb begin
        bus.rdData = '0;
        case (reg_sel_e'(bus.rdSel))
            RDSEL_KEY:     bus.rdData[NKEYS-1:0] = keyState;
            RDSEL_SW:      bus.rdData[NSW-1:0]   = swState;
            RDSEL_EVENTS:  bus.rdData[NKEYS-1:0] = events_q;
            RDSEL_IRQMASK: bus.rdData[NKEYS-1:0] = mask;
            default:       bus.rdData            = '0;
        endcase
    end

    logic unused_wrt;
    assign unused_wrt = &{1'b0, bus.wrtData[DBITS-1:NKEYS], 1'b0};

endmodule

// File: tb/tb_key_sw_debouncer.sv
// Directed bench for key_sw_debouncer with a short debounce depth of 4.
module tb_key_sw_debouncer;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] keyRaw;
    logic [9:0] swRaw;
    logic [3:0] keyState, keyPress;
    logic [9:0] swState;
`ifdef KEY_DEBOUNCER_IRQ_EN
    logic       irq;
`endif

    int n_vec = 0;
    int n_err = 0;

    key_sw_debouncer_if #(.DBITS(32)) bus ();

    key_sw_debouncer #(
        .DBITS(32), .NKEYS(4), .NSW(10), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .keyRaw   (keyRaw),
        .swRaw    (swRaw),
        .keyState (keyState),
        .swState  (swState),
        .keyPress (keyPress),
        .bus      (bus)
`ifdef KEY_DEBOUNCER_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        bus.rdSel = sel;
        #1;
        chk(tag, bus.rdData, exp);
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] data);
        bus.wrtEn = 1'b1; bus.wrtSel = sel; bus.wrtData = data;
        step(1);
        bus.wrtEn = 1'b0; bus.wrtData = '0;
    endtask

    initial begin
        keyRaw = 4'hF; swRaw = '0;
        bus.rdSel = '0; bus.wrtEn = 1'b0; bus.wrtSel = '0; bus.wrtData = '0;

        // reset state
        step(3);
        chk("rst_keyState", 32'(keyState), 32'h0);
        chk("rst_swState",  32'(swState),  32'h0);
        chk("rst_keyPress", 32'(keyPress), 32'h0);
        rd("rst_rd0", 2'd0, 32'h0);
        rd("rst_rd1", 2'd1, 32'h0);
        rd("rst_rd2", 2'd2, 32'h0);
        reset_n = 1'b1;
        step(2);

        // clean press on key 0: accepted on edge D+2, pulse one cycle later
        keyRaw = 4'b1110;
        step(D + 1);
        chk("k0_early", 32'(keyState), 32'h0);
        step(1);
        chk("k0_accept", 32'(keyState), 32'h1);
        chk("k0_nopulse_yet", 32'(keyPress), 32'h0);
        step(1);
        chk("k0_pulse", 32'(keyPress), 32'h1);
        rd("k0_ev_before", 2'd2, 32'h0);
        step(1);
        chk("k0_pulse_end", 32'(keyPress), 32'h0);
        rd("k0_ev", 2'd2, 32'h1);
        rd("k0_rd0", 2'd0, 32'h1);

        // key 1 low for only 3 samples
        keyRaw = 4'b1100;
        step(3);
        keyRaw = 4'b1110;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("k1_glitch_state", 32'(keyState), 32'h1);
            chk("k1_glitch_pulse", 32'(keyPress), 32'h0);
        end

        // switches bouncing every 2 cycles
        for (int k = 0; k < 12; k++) begin
            swRaw = ((k / 2) % 2 == 1) ? 10'h000 : 10'h3FF;
            step(1);
            chk("sw_bounce", 32'(swState), 32'h0);
        end
        step(D + 2);
        chk("sw_bounce_end", 32'(swState), 32'h0);

        // events = 0011, then W1C bit 0
        keyRaw = 4'b1100;
        step(10);
        rd("ev_0011", 2'd2, 32'h3);
        wr(2'd2, 32'h1);
        rd("ev_w1c", 2'd2, 32'h2);
        wr(2'd0, 32'hF);
        wr(2'd1, 32'hF);
        rd("ev_ignored_wr", 2'd2, 32'h2);
        rd("rd3_mask0", 2'd3, 32'h0);

        // release key 0: no pulse, no event
        keyRaw = 4'b1101;
        step(10);
        chk("k0_release", 32'(keyState), 32'h2);
        rd("ev_release", 2'd2, 32'h2);

        // re-press key 0 and W1C both bits while its pulse is live
        keyRaw = 4'b1100;
        step(D + 3);
        chk("k0_repulse", 32'(keyPress), 32'h1);
        wr(2'd2, 32'h3);
        rd("ev_set_wins", 2'd2, 32'h1);

        // switch pattern
        swRaw = 10'h2A5;
        step(D + 1);
        rd("sw_early", 2'd1, 32'h0);
        step(1);
        rd("sw_accept", 2'd1, 32'h2A5);

        // reset mid-count
        swRaw = 10'h000;
        step(3);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_sw",  32'(swState),  32'h0);
        chk("rst_mid_key", 32'(keyState), 32'h0);
        rd("rst_mid_ev", 2'd2, 32'h0);
        step(2);
        swRaw = 10'h2A5;
        reset_n = 1'b1;
        step(D + 1);
        rd("post_rst_early", 2'd1, 32'h0);
        chk("post_rst_key_early", 32'(keyState), 32'h0);
        step(1);
        rd("post_rst_sw", 2'd1, 32'h2A5);
        chk("post_rst_key", 32'(keyState), 32'h3);

`ifdef KEY_DEBOUNCER_IRQ_EN
        step(4);
        rd("irq_ev_pre", 2'd2, 32'h3);
        wr(2'd3, 32'h4);
        rd("irq_mask", 2'd3, 32'h4);
        chk("irq_idle", 32'(irq), 32'h0);
        keyRaw = 4'b1000;
        step(D + 4);
        rd("irq_ev_set", 2'd2, 32'h7);
        chk("irq_not_yet", 32'(irq), 32'h0);
        step(1);
        chk("irq_assert", 32'(irq), 32'h1);
        wr(2'd2, 32'h4);
        rd("irq_ev_clr", 2'd2, 32'h3);
        chk("irq_hold", 32'(irq), 32'h1);
        step(1);
        chk("irq_deassert", 32'(irq), 32'h0);
        keyRaw = 4'b0000;
        step(10);
        rd("irq_k3_ev", 2'd2, 32'hB);
        chk("irq_k3_masked", 32'(irq), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
